// File: rtl/write_request_scheduler.sv
// write_request_scheduler
// Round-robin arbiter that shares one host write-request queue between
// N_STREAMS writers. In-flight transfers are limited by per-stream and global
// credit counters; credits come back through demultiplexed write completions.
module write_request_scheduler #(
    parameter  int N_STREAMS          = 4,
    parameter  int REQ_W              = 128,
    parameter  int MAX_OUTSTANDING    = 8,
    parameter  int GLOBAL_OUTSTANDING = 16,
    localparam int ID_W               = $clog2(N_STREAMS),
    localparam int CNT_W              = $clog2(MAX_OUTSTANDING + 1),
    localparam int GCNT_W             = $clog2(GLOBAL_OUTSTANDING + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_STREAMS-1:0]         req_valid,
    output logic [N_STREAMS-1:0]         req_ready,
    input  logic [N_STREAMS*REQ_W-1:0]   req_data,
    output logic                         sq_valid,
    input  logic                         sq_ready,
    output logic [REQ_W-1:0]             sq_data,
    output logic [ID_W-1:0]              sq_strm,
    input  logic                         cpl_valid,
    input  logic [ID_W-1:0]              cpl_strm,
    output logic                         cpl_ready,
    output logic [N_STREAMS*CNT_W-1:0]   outstanding,
    output logic [GCNT_W-1:0]            global_outstanding,
    output logic                         idle,
    output logic                         err_underflow
);

    // State registers
    logic                 sq_valid_q, sq_valid_d;
    logic [REQ_W-1:0]     sq_data_q,  sq_data_d;
    logic [ID_W-1:0]      sq_strm_q,  sq_strm_d;
    logic [ID_W-1:0]      rr_q,       rr_d;
    logic [CNT_W-1:0]     cnt_q [N_STREAMS];
    logic [CNT_W-1:0]     cnt_d [N_STREAMS];
    logic [GCNT_W-1:0]    gcnt_q,     gcnt_d;
    logic                 err_q,      err_d;

    // Arbitration / credit intermediates
    logic                 slot_free;
    logic                 found;
    logic [ID_W-1:0]      win;
    logic [N_STREAMS-1:0] elig;
    logic [N_STREAMS-1:0] grant;
    logic [N_STREAMS-1:0] dec;
    logic                 any_dec;
    logic                 underflow;

    // Eligibility and round-robin winner search starting at the rr pointer.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch can be inferred on any path.
    always_comb begin
        int idx;
        slot_free = !sq_valid_q || sq_ready;
        found     = 1'b0;
        win       = '0;
        idx       = 0;
        grant     = '0;
        for (int i = 0; i < N_STREAMS; i++) begin
            elig[i] = req_valid[i]
                   && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING))
                   && (gcnt_q < GCNT_W'(GLOBAL_OUTSTANDING));
        end
        for (int k = 0; k < N_STREAMS; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_STREAMS) idx = idx - N_STREAMS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        for (int i = 0; i < N_STREAMS; i++) begin
            grant[i] = slot_free && found && (win == ID_W'(i));
        end
    end

    // Output slot load/hold/drain and rr pointer advance.
    always_comb begin
        sq_valid_d = sq_valid_q;
        sq_data_d  = sq_data_q;
        sq_strm_d  = sq_strm_q;
        rr_d       = rr_q;
        if (slot_free) begin
            sq_valid_d = found;
            if (found) begin
                sq_data_d = req_data[int'(win)*REQ_W +: REQ_W];
                sq_strm_d = win;
                rr_d      = (int'(win) == N_STREAMS - 1) ? '0 : win + ID_W'(1);
            end
        end
    end

    // Credit accounting: +1 on acceptance, -1 on a valid completion.
    // Completions for an empty or nonexistent stream are dropped and flagged.
    always_comb begin
        for (int i = 0; i < N_STREAMS; i++) begin
            dec[i] = cpl_valid && (cpl_strm == ID_W'(i)) && (cnt_q[i] != '0);
        end
        any_dec   = |dec;
        underflow = cpl_valid && !any_dec;
        for (int i = 0; i < N_STREAMS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grant[i] && !dec[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (!grant[i] && dec[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        gcnt_d = gcnt_q;
        if ((|grant) && !any_dec)      gcnt_d = gcnt_q + GCNT_W'(1);
        else if (!(|grant) && any_dec) gcnt_d = gcnt_q - GCNT_W'(1);
        err_d = err_q || underflow;
    end

    // State register with asynchronous active-low reset.
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_valid_q <= 1'b0;
            sq_data_q  <= '0;
            sq_strm_q  <= '0;
            rr_q       <= '0;
            gcnt_q     <= '0;
            err_q      <= 1'b0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it
            // is reset element by element like any other state.
            for (int i = 0; i < N_STREAMS; i++) cnt_q[i] <= '0;
        end else begin
            sq_valid_q <= sq_valid_d;
            sq_data_q  <= sq_data_d;
            sq_strm_q  <= sq_strm_d;
            rr_q       <= rr_d;
            gcnt_q     <= gcnt_d;
            err_q      <= err_d;
            for (int i = 0; i < N_STREAMS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Output mapping and idle detection.
    always_comb begin
        logic all_zero;
        all_zero = (gcnt_q == '0);
        for (int i = 0; i < N_STREAMS; i++) begin
            outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
            if (cnt_q[i] != '0) all_zero = 1'b0;
        end
        req_ready          = grant;
        sq_valid           = sq_valid_q;
        sq_data            = sq_data_q;
        sq_strm            = sq_strm_q;
        cpl_ready          = 1'b1;
        global_outstanding = gcnt_q;
        err_underflow      = err_q;
        idle               = all_zero && !sq_valid_q;
    end

    // A stalled request must not change under the host queue.
    a_sq_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (sq_valid_q && !sq_ready) |=> (sq_valid_q && $stable(sq_data_q) && $stable(sq_strm_q)));

endmodule

// File: tb/tb_write_request_scheduler.sv
// Testbench for write_request_scheduler: table-driven round-robin vectors,
// hand-written credit/stall/reset sequences and a payload scoreboard.
module tb_write_request_scheduler;

    localparam int N      = 4;
    localparam int W      = 128;
    localparam int MAXO   = 8;
    localparam int GO     = 16;
    localparam int ID_W   = $clog2(N);
    localparam int CNT_W  = $clog2(MAXO + 1);
    localparam int GCNT_W = $clog2(GO + 1);

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_data;
    logic              sq_valid;
    logic              sq_ready;
    logic [W-1:0]      sq_data;
    logic [ID_W-1:0]   sq_strm;
    logic              cpl_valid;
    logic [ID_W-1:0]   cpl_strm;
    logic              cpl_ready;
    logic [N*CNT_W-1:0] outstanding;
    logic [GCNT_W-1:0] global_outstanding;
    logic              idle;
    logic              err_underflow;

    write_request_scheduler #(
        .N_STREAMS(N), .REQ_W(W), .MAX_OUTSTANDING(MAXO), .GLOBAL_OUTSTANDING(GO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_data(sq_data), .sq_strm(sq_strm),
        .cpl_valid(cpl_valid), .cpl_strm(cpl_strm), .cpl_ready(cpl_ready),
        .outstanding(outstanding), .global_outstanding(global_outstanding),
        .idle(idle), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0]    data;
        logic [ID_W-1:0] strm;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        logic [N-1:0]    rv;
        logic [N-1:0]    exp_rdy;
        logic            exp_sv;
        logic [ID_W-1:0] exp_strm;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] out_of(input int i);
        return outstanding[i*CNT_W +: CNT_W];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_payloads;
        for (int i = 0; i < N; i++)
            req_data[i*W +: W] = {32'(i + 1), 32'hCAFEF00D, 32'(i * 7), 32'h12345678};
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        cpl_valid = 1'b0;
        cpl_strm  = '0;
        sq_ready  = 1'b0;
        set_payloads();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Scoreboard: expected payloads pushed on acceptance, popped on sq handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (sq_valid && sq_ready) begin
                check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_strm", 128'(sq_strm), 128'(mon_e.strm));
                    check("sb_data", sq_data, mon_e.data);
                end
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i])
                    sb_q.push_back('{data: req_data[i*W +: W], strm: ID_W'(i)});
        end
    end

    initial begin
        int grants;

        tbl[0] = '{4'hF, 4'b0001, 1'b0, 2'd0};
        tbl[1] = '{4'hF, 4'b0010, 1'b1, 2'd0};
        tbl[2] = '{4'hF, 4'b0100, 1'b1, 2'd1};
        tbl[3] = '{4'hF, 4'b1000, 1'b1, 2'd2};
        tbl[4] = '{4'hF, 4'b0001, 1'b1, 2'd3};
        tbl[5] = '{4'hF, 4'b0010, 1'b1, 2'd0};
        tbl[6] = '{4'h0, 4'b0000, 1'b1, 2'd1};
        tbl[7] = '{4'h0, 4'b0000, 1'b0, 2'd0};

        // Reset state
        do_reset();
        #1;
        check("rst_sq_valid", 128'(sq_valid), 128'(0));
        check("rst_sq_data", sq_data, 128'(0));
        check("rst_sq_strm", 128'(sq_strm), 128'(0));
        check("rst_global", 128'(global_outstanding), 128'(0));
        check("rst_outstanding", 128'(outstanding), 128'(0));
        check("rst_idle", 128'(idle), 128'(1));
        check("rst_err", 128'(err_underflow), 128'(0));
        check("rst_cpl_ready", 128'(cpl_ready), 128'(1));
        check("rst_req_ready", 128'(req_ready), 128'(0));

        // Round robin over all four streams, table driven
        sq_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            req_valid = tbl[r].rv;
            #1;
            check($sformatf("rr_rdy[%0d]", r), 128'(req_ready), 128'(tbl[r].exp_rdy));
            check($sformatf("rr_sv[%0d]", r), 128'(sq_valid), 128'(tbl[r].exp_sv));
            if (tbl[r].exp_sv)
                check($sformatf("rr_strm[%0d]", r), 128'(sq_strm), 128'(tbl[r].exp_strm));
            tick();
        end
        check("rr_out0", 128'(out_of(0)), 128'(2));
        check("rr_out1", 128'(out_of(1)), 128'(2));
        check("rr_out2", 128'(out_of(2)), 128'(1));
        check("rr_out3", 128'(out_of(3)), 128'(1));
        check("rr_global", 128'(global_outstanding), 128'(6));
        check("rr_idle", 128'(idle), 128'(0));

        // Per-stream limit on stream 1
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'b0010;
        grants    = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[1]) grants++;
            tick();
        end
        #1;
        check("lim_grants", 128'(grants), 128'(8));
        check("lim_out1", 128'(out_of(1)), 128'(8));
        check("lim_global", 128'(global_outstanding), 128'(8));
        check("lim_rdy", 128'(req_ready), 128'(0));
        cpl_valid = 1'b1;
        cpl_strm  = 2'd1;
        #1;
        check("lim_cpl_rdy", 128'(req_ready), 128'(0));
        tick();
        cpl_valid = 1'b0;
        grants    = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_ready[1]) grants++;
            tick();
        end
        #1;
        check("lim_regrant", 128'(grants), 128'(1));
        check("lim_out1_after", 128'(out_of(1)), 128'(8));

        // Global limit with all streams
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'hF;
        grants    = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            grants += $countones(req_ready);
            tick();
        end
        #1;
        check("glb_grants", 128'(grants), 128'(16));
        check("glb_global", 128'(global_outstanding), 128'(16));
        for (int i = 0; i < N; i++)
            check($sformatf("glb_out%0d", i), 128'(out_of(i)), 128'(4));
        cpl_valid = 1'b1;
        cpl_strm  = 2'd2;
        #1;
        check("glb_cpl_rdy", 128'(req_ready), 128'(0));
        tick();
        cpl_valid = 1'b0;
        #1;
        check("glb_regrant", 128'(req_ready), 128'(4'b0001));
        tick();
        grants = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            grants += $countones(req_ready);
            tick();
        end
        #1;
        check("glb_no_more", 128'(grants), 128'(0));
        check("glb_out0", 128'(out_of(0)), 128'(5));
        check("glb_out2", 128'(out_of(2)), 128'(3));
        check("glb_global_after", 128'(global_outstanding), 128'(16));

        // Stall with stream 2 payload held in the slot
        do_reset();
        req_data[2*W +: W] = 128'hAB;
        sq_ready  = 1'b0;
        req_valid = 4'b0100;
        #1;
        check("stl_first_rdy", 128'(req_ready), 128'(4'b0100));
        tick();
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("stl_sv[%0d]", c), 128'(sq_valid), 128'(1));
            check($sformatf("stl_data[%0d]", c), sq_data, 128'hAB);
            check($sformatf("stl_strm[%0d]", c), 128'(sq_strm), 128'(2));
            check($sformatf("stl_rdy[%0d]", c), 128'(req_ready), 128'(0));
            tick();
        end
        sq_ready = 1'b1;
        #1;
        check("stl_resume_rdy", 128'(req_ready), 128'(4'b1000));
        tick();
        req_valid = '0;
        #1;
        check("stl_resume_sv", 128'(sq_valid), 128'(1));
        check("stl_resume_strm", 128'(sq_strm), 128'(3));
        tick();

        // Same-cycle grant/completion and underflow
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("sc_rdy[%0d]", c), 128'(req_ready), 128'(4'b0001));
            tick();
        end
        req_valid = '0;
        #1;
        check("sc_pre_out0", 128'(out_of(0)), 128'(3));
        check("sc_pre_global", 128'(global_outstanding), 128'(3));
        req_valid = 4'b0001;
        cpl_valid = 1'b1;
        cpl_strm  = 2'd0;
        #1;
        check("sc_same_rdy", 128'(req_ready), 128'(4'b0001));
        tick();
        req_valid = '0;
        cpl_valid = 1'b0;
        #1;
        check("sc_same_out0", 128'(out_of(0)), 128'(3));
        check("sc_same_global", 128'(global_outstanding), 128'(3));
        req_valid = 4'b0010;
        cpl_valid = 1'b1;
        cpl_strm  = 2'd0;
        #1;
        check("sc_diff_rdy", 128'(req_ready), 128'(4'b0010));
        tick();
        req_valid = '0;
        cpl_valid = 1'b0;
        #1;
        check("sc_diff_out0", 128'(out_of(0)), 128'(2));
        check("sc_diff_out1", 128'(out_of(1)), 128'(1));
        check("sc_diff_global", 128'(global_outstanding), 128'(3));
        cpl_valid = 1'b1;
        cpl_strm  = 2'd3;
        tick();
        cpl_valid = 1'b0;
        #1;
        check("uf_out0", 128'(out_of(0)), 128'(2));
        check("uf_out1", 128'(out_of(1)), 128'(1));
        check("uf_out3", 128'(out_of(3)), 128'(0));
        check("uf_global", 128'(global_outstanding), 128'(3));
        check("uf_err", 128'(err_underflow), 128'(1));
        tick();
        tick();
        tick();
        check("uf_err_sticky", 128'(err_underflow), 128'(1));
        rst_n = 1'b0;
        #1;
        check("uf_err_rst", 128'(err_underflow), 128'(0));
        tick();
        rst_n = 1'b1;
        #1;
        check("uf_err_after_rst", 128'(err_underflow), 128'(0));

        // Asynchronous reset mid-burst
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'hF;
        cpl_valid = 1'b1;
        cpl_strm  = 2'd3;
        tick();
        cpl_valid = 1'b0;
        tick();
        tick();
        #1;
        check("ar_pre_sv", 128'(sq_valid), 128'(1));
        check("ar_pre_err", 128'(err_underflow), 128'(1));
        check("ar_pre_global", 128'(global_outstanding), 128'(3));
        rst_n = 1'b0;
        #1;
        check("ar_sv", 128'(sq_valid), 128'(0));
        check("ar_data", sq_data, 128'(0));
        check("ar_global", 128'(global_outstanding), 128'(0));
        check("ar_outstanding", 128'(outstanding), 128'(0));
        check("ar_err", 128'(err_underflow), 128'(0));
        check("ar_idle", 128'(idle), 128'(1));
        tick();
        rst_n = 1'b1;
        #1;
        check("ar_first_rdy", 128'(req_ready), 128'(4'b0001));
        tick();
        req_valid = '0;
        #1;
        check("ar_first_sv", 128'(sq_valid), 128'(1));
        check("ar_first_strm", 128'(sq_strm), 128'(0));
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
